// File: rtl/obi_mailbox_responder.sv
// obi_mailbox_responder
// Zero-wait OBI data-bus responder. It exposes a store-driven mailbox FIFO
// in a 16-byte window, and the FIFO drains through a valid/ready stream port.
// Register map, selected by addr[3:2]:
//   0 DATA   : write pushes a word, read peeks the head
//   1 STATUS : count / overflow / full / empty
//   2 CTRL   : bit0 flush, bit1 clear overflow
//   3 THRESH : irq threshold
module obi_mailbox_responder #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic                  overflow_reg;
  logic [7:0]            thresh_reg;
  logic                  irq_reg;
  logic                  rvalid_reg, err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [1:0]            sel;
  logic                  wr_acc, rd_acc;
  logic                  empty, full;
  logic                  flush, ovf_clr, thresh_wr;
  logic                  push_req, push_ok, push_drop, pop;
  logic [31:0]           count_ext, status_word;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic                  err_next;

  // Decode the current request and derive the FIFO push/pop/flush strobes
  always_comb begin
    sel       = addr_i[3:2];
    wr_acc    = req_i & we_i;
    rd_acc    = req_i & ~we_i;
    empty     = (count_reg == '0);
    full      = (count_reg == CW'(DEPTH));
    flush     = wr_acc && (sel == REG_CTRL) && be_i[0] && wdata_i[0];
    ovf_clr   = wr_acc && (sel == REG_CTRL) && be_i[0] && wdata_i[1];
    thresh_wr = wr_acc && (sel == REG_THRESH) && be_i[0];
    // A flush voids any pop in the same cycle
    pop       = !empty && m_ready_i && !flush;
    push_req  = wr_acc && (sel == REG_DATA) && (be_i == 4'hF);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_ok   = push_req && !flush && (!full || pop);
    push_drop = push_req && full && !pop;
    count_next = flush ? '0 : (count_reg + CW'(push_ok) - CW'(pop));
    count_ext   = 32'(count_reg);
    status_word = {16'h0000, count_ext[7:0], 5'b00000, overflow_reg, full, empty};
  end

  // Build the response word and error flag for a request granted this cycle
  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    if (req_i) begin
      case (sel)
        REG_DATA: begin
          if (we_i) begin
            err_next = (be_i != 4'hF) || push_drop;
          end else if (empty) begin
            err_next = 1'b1;
          end else begin
            rdata_next = mem[rd_ptr_reg];
          end
        end
        REG_STATUS: begin
          if (we_i) err_next = 1'b1;
          else      rdata_next = status_word;
        end
        REG_CTRL: begin
          rdata_next = '0;
        end
        default: begin
          if (rd_acc) rdata_next = {24'h000000, thresh_reg};
        end
      endcase
    end
  end

  // FIFO storage; no reset needed because the head is masked while empty
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata_i;
  end

  // FIFO pointers, occupancy, sticky overflow, threshold and interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      thresh_reg   <= 8'h00;
      irq_reg      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      if (push_drop)    overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (thresh_wr) thresh_reg <= wdata_i[7:0];
      // Registered compare: follows a count change by one cycle
      irq_reg <= (thresh_reg != 8'h00) && (count_ext >= 32'(thresh_reg));
    end
  end

  // OBI response pipeline: exactly one cycle after each grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= req_i;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_reg;
  assign rdata_o   = rdata_reg;
  assign err_o     = err_reg;
  assign m_valid_o = !empty;
  assign m_data_o  = empty ? '0 : mem[rd_ptr_reg];
  assign irq_o     = irq_reg;

  // Address bits outside the decoded window are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], count_ext[31:8]};

endmodule

// File: tb/tb_obi_mailbox_responder.sv
// tb_obi_mailbox_responder
// Directed plus randomized stimulus against a queue-based mailbox model.
module tb_obi_mailbox_responder;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i;
  logic        irq_o;

  obi_mailbox_responder #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: FIFO contents, sticky overflow, threshold
  logic [31:0] q [$];
  bit          ovf;
  int          thr;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf = 1'b0;
    thr = 0;
  endtask

  function automatic logic [31:0] status_of(input int sz, input bit o);
    logic [31:0] s;
    logic [31:0] c;
    c = 32'(sz);
    s = 32'h0;
    s[15:8] = c[7:0];
    s[2] = o;
    s[1] = (sz == DEPTH);
    s[0] = (sz == 0);
    return s;
  endfunction

  // One clock cycle: drive inputs, predict, clock, compare every output
  task automatic cyc(input bit req, input bit we, input logic [1:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input bit rdy);
    logic [31:0] r, e_rd, e_head;
    bit e_err, e_irq, pop, flush, full, push_go;
    int sz;
    r = $urandom();
    req_i = req; we_i = we; addr_i = {r[31:4], a, r[1:0]};
    be_i = be; wdata_i = wd; m_ready_i = rdy;
    #1;
    check("gnt", 32'(gnt_o), 32'(req));
    sz      = q.size();
    full    = (sz == DEPTH);
    e_irq   = (thr != 0) && (sz >= thr);
    flush   = req && we && (a == 2'd2) && be[0] && wd[0];
    pop     = !flush && (sz > 0) && rdy;
    push_go = 1'b0;
    e_rd    = 32'h0;
    e_err   = 1'b0;
    if (req) begin
      case (a)
        2'd0: begin
          if (we) begin
            if (be != 4'hF) e_err = 1'b1;
            else if (full && !pop) begin e_err = 1'b1; ovf = 1'b1; end
            else push_go = 1'b1;
          end else if (sz == 0) e_err = 1'b1;
          else e_rd = q[0];
        end
        2'd1: begin
          if (we) e_err = 1'b1;
          else e_rd = status_of(sz, ovf);
        end
        2'd2: begin
          if (we && be[0] && wd[1]) ovf = 1'b0;
        end
        default: begin
          if (we) begin
            if (be[0]) thr = int'(wd[7:0]);
          end else e_rd = 32'(thr);
        end
      endcase
    end
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push_go) q.push_back(wd);
    end
    e_head = (q.size() > 0) ? q[0] : 32'h0;
    @(posedge clk_i);
    #1;
    check("rvalid", 32'(rvalid_o), 32'(req));
    check("rdata", rdata_o, e_rd);
    check("err", 32'(err_o), 32'(e_err));
    check("m_valid", 32'(m_valid_o), 32'(q.size() > 0));
    check("m_data", m_data_o, e_head);
    check("irq", 32'(irq_o), 32'(e_irq));
    if (req)
      $display("txn we=%0b reg=%0d be=%h wdata=%08h -> rdata=%08h err=%0b count=%0d",
               we, a, be, wd, rdata_o, err_o, q.size());
  endtask

  task automatic push(input logic [31:0] wd, input bit rdy);
    cyc(1'b1, 1'b1, 2'd0, 4'hF, wd, rdy);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(1'b1, 1'b1, a, 4'hF, wd, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] exp_words [3];
    logic [31:0] r;
    bit rq, w, rdy;
    logic [1:0] a;
    logic [3:0] be;
    logic [31:0] wd;

    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
    be_i = 4'h0; wdata_i = '0; m_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_m_valid", 32'(m_valid_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    rst_i = 1'b0;

    // Reset while a STATUS read is being granted
    push(32'h77, 1'b0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; be_i = 4'hF; m_ready_i = 1'b0;
    #1 rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    check("midrst_rvalid", 32'(rvalid_o), 32'h0);
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_err", 32'(err_o), 32'h0);
    check("midrst_m_valid", 32'(m_valid_o), 32'h0);
    check("midrst_m_data", m_data_o, 32'h0);
    check("midrst_irq", 32'(irq_o), 32'h0);
    req_i = 1'b0;
    rst_i = 1'b0;
    idle(1'b0);
    rd(2'd1);
    check("status_after_rst", rdata_o, 32'h1);

    // Three pushes, then drain in order
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      push(exp_words[i], 1'b0);
      check("push_err", 32'(err_o), 32'h0);
    end
    rd(2'd1);
    check("status_3", rdata_o, 32'h300);
    check("head_11", m_data_o, 32'h11);
    for (int i = 0; i < 3; i++) begin
      check("drain", m_data_o, exp_words[i]);
      idle(1'b1);
    end
    check("drained_valid", 32'(m_valid_o), 32'h0);

    // Overflow and push-while-popping at full
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i), 1'b0);
    push(32'hDEAD, 1'b0);
    check("ovf_err", 32'(err_o), 32'h1);
    rd(2'd1);
    check("status_ovf", rdata_o, 32'h806);
    push(32'hBEEF, 1'b1);
    check("full_pushpop_err", 32'(err_o), 32'h0);
    rd(2'd1);
    check("status_full_again", rdata_o, 32'h806);
    wr(2'd2, 32'h2);
    rd(2'd1);
    check("status_ovf_clr", rdata_o, 32'h802);
    wr(2'd2, 32'h1);
    rd(2'd1);
    check("status_flushed", rdata_o, 32'h1);

    // Back-to-back push/read, empty read, partial-byte DATA write
    push(32'hA5, 1'b0);
    rd(2'd0);
    check("peek_a5", rdata_o, 32'hA5);
    idle(1'b1);
    rd(2'd0);
    check("empty_read_err", 32'(err_o), 32'h1);
    cyc(1'b1, 1'b1, 2'd0, 4'h3, 32'h55, 1'b0);
    check("be3_err", 32'(err_o), 32'h1);
    rd(2'd1);
    check("be3_status", rdata_o, 32'h1);

    // Threshold interrupt
    wr(2'd3, 32'h3);
    rd(2'd3);
    check("thresh_rd", rdata_o, 32'h3);
    push(32'h1, 1'b0); push(32'h2, 1'b0); push(32'h3, 1'b0);
    check("irq_lag", 32'(irq_o), 32'h0);
    idle(1'b0);
    check("irq_set", 32'(irq_o), 32'h1);
    idle(1'b1);
    idle(1'b0);
    check("irq_clr", 32'(irq_o), 32'h0);
    wr(2'd3, 32'h0);
    for (int i = 0; i < 6; i++) push(32'h40 + 32'(i), 1'b0);
    idle(1'b0);
    check("irq_thr0", 32'(irq_o), 32'h0);

    // Flush with 5 entries while the consumer is ready
    wr(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 2'd2, 4'hF, 32'h1, 1'b1);
    check("flush_err", 32'(err_o), 32'h0);
    check("flush_valid", 32'(m_valid_o), 32'h0);

    // Wrap-around: 20 words with a randomly stalling consumer
    for (int i = 0; i < 20; i++) begin
      r = $urandom();
      push(r, r[0]);
    end
    for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
    check("wrap_empty", 32'(m_valid_o), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r   = $urandom();
      rq  = (r[1:0] != 2'b00);
      w   = r[2];
      a   = r[4:3];
      be  = (r[7:5] == 3'b000) ? r[11:8] : 4'hF;
      rdy = r[12];
      wd  = $urandom();
      if (a == 2'd2) wd = (r[15:13] == 3'b000) ? (wd & 32'h3) : (wd & 32'h2);
      if (a == 2'd3) wd = wd & 32'h7;
      cyc(rq, w, a, be, wd, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
